// File: rtl/fan_regulator_if.sv
// Fan regulator pin bundle: raw switch and step contacts in, fan controller drive out.
// master = contact side (bench or board), slave = the regulator itself.
interface fan_regulator_if;
  logic       pwr_sw;
  logic       knob_up;
  logic       knob_dn;
  logic       elec;
  logic [2:0] mod;
  logic [2:0] target;
  logic       busy;

  modport master (
    output pwr_sw, knob_up, knob_dn,
    input  elec, mod, target, busy
  );

  modport slave (
    input  pwr_sw, knob_up, knob_dn,
    output elec, mod, target, busy
  );
endinterface

// File: rtl/fan_regulator.sv
// Fan regulator: synchronizes and debounces the mains switch and the two regulator
// contacts, holds the requested mode (target) and drives the fan controller (elec, mod).
// Optional feature macro FAN_SOFT_START_EN: when defined, mod walks one step toward
// target every RAMP_CYCLES clocks; when undefined, mod follows target one edge later.
module fan_regulator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RAMP_CYCLES     = 8,
  parameter int unsigned MAX_MODE        = 3
) (
  input logic            clk,
  input logic            rst_n,
  fan_regulator_if.slave bus
);

  localparam logic [7:0] DbLast  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] MaxMode = 3'(MAX_MODE);

  typedef enum logic [1:0] {StOff, StIdle, StRamp} state_e;

  // Bit 0: pwr_sw, bit 1: knob_up, bit 2: knob_dn.
  logic [2:0]      raw;
  logic [2:0]      s1_q, s2_q, db_q;
  logic [2:0][7:0] dcnt_q;
  logic [1:0]      db_prev_q;   // up/down levels only
  logic [1:0]      arm_q;       // step contact seen low since reset
  logic [1:0]      rsync_q;
  logic            en;
  logic            pwr_on, up_evt, dn_evt;

  logic [2:0] target_q, target_d;
  logic [2:0] mod_q, mod_d;
  logic       elec_q, busy_q;
  state_e     state_q, state_d;

  assign raw = {bus.knob_dn, bus.knob_up, bus.pwr_sw};

  // Reset release is re-timed so no state moves before the second edge after deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync_q <= '0;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end
  assign en = rsync_q[1];

  // Two-flop synchronizers for the raw asynchronous levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Per-input debouncers plus edge history and re-arm tracking for the step contacts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= '0;
      dcnt_q    <= '0;
      db_prev_q <= '0;
      arm_q     <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == db_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DbLast) begin
          db_q[i]   <= ~db_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 8'd1;
        end
      end
      db_prev_q <= db_q[2:1];
      // A step contact held through reset must go low before its next rise counts.
      arm_q     <= arm_q | ~s2_q[2:1];
    end
  end

  assign pwr_on = db_q[0];
  assign up_evt = db_q[1] & ~db_prev_q[0] & arm_q[0];
  assign dn_evt = db_q[2] & ~db_prev_q[1] & arm_q[1];

  // Saturating target update; simultaneous up and down cancel.
  always_comb begin
    target_d = target_q;
    if (up_evt && !dn_evt) begin
      if (target_q != MaxMode) target_d = target_q + 3'd1;
    end else if (dn_evt && !up_evt) begin
      if (target_q != '0) target_d = target_q - 3'd1;
    end
  end

`ifdef FAN_SOFT_START_EN
  localparam logic [7:0] RampLast = 8'(RAMP_CYCLES - 1);
  logic [7:0] rcnt_q, rcnt_d;

  // Ramp pacing counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end
`else
  // RAMP_CYCLES has no effect without soft start; referenced so both builds share one
  // parameter set.
  if (RAMP_CYCLES == 0) begin : g_ramp_cycles_unused
  end
`endif

  // Power/mode FSM next state; state is decided from next-cycle mod/target so busy
  // and the ramp counter start on the same edge target moves.
  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
`ifdef FAN_SOFT_START_EN
    rcnt_d  = '0;
`endif
    if (!pwr_on) begin
      state_d = StOff;
      mod_d   = '0;
    end else if (state_q == StOff) begin
      mod_d   = '0;
      state_d = (target_d != '0) ? StRamp : StIdle;
    end else begin
`ifdef FAN_SOFT_START_EN
      if (state_q == StRamp) begin
        if (rcnt_q == RampLast) begin
          if (mod_q < target_q)      mod_d = mod_q + 3'd1;
          else if (mod_q > target_q) mod_d = mod_q - 3'd1;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
`else
      mod_d = target_q;
`endif
      state_d = (mod_d != target_d) ? StRamp : StIdle;
`ifdef FAN_SOFT_START_EN
      if (state_d != StRamp) rcnt_d = '0;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      target_q <= '0;
      mod_q    <= '0;
      elec_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mod_q    <= mod_d;
      elec_q   <= (state_d != StOff);
      busy_q   <= (state_d == StRamp);
    end
  end

  assign bus.elec   = elec_q;
  assign bus.mod    = mod_q;
  assign bus.target = target_q;
  assign bus.busy   = busy_q;

endmodule
